// File: rtl/clock_seq.sv
// clock_seq: sequences the toggle-clock stage by emitting one-cycle rollover strobes
// every div system clocks. Define CLOCK_SEQ_BURST_EN to add the fixed-length BURST mode.
module clock_seq #(
    parameter int W_DIV       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_div_valid,
    input  logic [W_DIV-1:0] i_div,
    output logic             o_div_ready,
    output logic             o_roll_over,
    output logic             o_clk_level,
    output logic             o_running
`ifdef CLOCK_SEQ_BURST_EN
    ,
    input  logic [7:0]       i_burst_len,
    input  logic             i_burst_start,
    output logic             o_burst_done
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
`ifdef CLOCK_SEQ_BURST_EN
        ,
        S_BURST = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [W_DIV-1:0] count_q, count_d;
    logic [W_DIV-1:0] div_q, div_d;
    logic [W_DIV-1:0] eff_div;
    logic             roll_q, roll_d;
    logic             level_q, level_d;
    logic             running_q, running_d;
    logic             at_last;
    logic             roll_evt;
    logic             level_after;
    logic             div_ready;
`ifdef CLOCK_SEQ_BURST_EN
    logic [8:0]       rem_q, rem_d;
    logic             done_q, done_d;
`endif

    // A zero divisor behaves as one so the counter always has a terminal count.
    assign eff_div     = (div_q == '0) ? W_DIV'(1) : div_q;
    assign at_last     = (count_q == eff_div - W_DIV'(1));
    assign roll_evt    = (state_q != S_IDLE) && at_last;
    assign level_after = level_q ^ roll_evt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            div_q     <= W_DIV'(DEFAULT_DIV);
            roll_q    <= 1'b0;
            level_q   <= 1'b1;
            running_q <= 1'b0;
`ifdef CLOCK_SEQ_BURST_EN
            rem_q     <= '0;
            done_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            roll_q    <= roll_d;
            level_q   <= level_d;
            running_q <= running_d;
`ifdef CLOCK_SEQ_BURST_EN
            rem_q     <= rem_d;
            done_q    <= done_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef CLOCK_SEQ_BURST_EN
                if (i_burst_start && (i_burst_len != 8'd0)) begin
                    state_d = S_BURST;
                end else
`endif
                if (i_run) begin
                    state_d = S_RUN;
                end
            end
            // A rollover on the stop edge lands first; the resulting level picks the exit.
            S_RUN: begin
                if (!i_run) begin
                    state_d = level_after ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (roll_evt) begin
                    state_d = S_IDLE;
                end
            end
`ifdef CLOCK_SEQ_BURST_EN
            S_BURST: begin
                if (roll_evt && (rem_q == 9'd1)) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if ((state_q == S_IDLE) || (state_d == S_IDLE) || at_last) begin
            count_d = '0;
        end else begin
            count_d = count_q + W_DIV'(1);
        end
        // Ready only on the last count of a period, so a new divisor starts on a boundary.
        div_ready = (state_q == S_IDLE) || ((state_q == S_RUN) && at_last);
        div_d     = (i_div_valid && div_ready) ? i_div : div_q;
        roll_d    = roll_evt;
        level_d   = level_after;
        running_d = (state_d == S_RUN) || (state_d == S_DRAIN);
`ifdef CLOCK_SEQ_BURST_EN
        rem_d  = rem_q;
        done_d = (state_q == S_BURST) && (state_d == S_IDLE);
        if ((state_q == S_IDLE) && (state_d == S_BURST)) begin
            rem_d = {i_burst_len, 1'b0};
        end else if ((state_q == S_BURST) && roll_evt) begin
            rem_d = rem_q - 9'd1;
        end
`endif
    end

    assign o_div_ready = div_ready;
    assign o_roll_over = roll_q;
    assign o_clk_level = level_q;
    assign o_running   = running_q;
`ifdef CLOCK_SEQ_BURST_EN
    assign o_burst_done = done_q;
`endif

endmodule

// File: tb/tb_clock_seq.sv
// Self-checking bench for clock_seq: directed steps followed by random stimulus,
// compared against a timestamp-based model of the rollover schedule.
module tb_clock_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        div_valid;
    logic [15:0] div;
    logic        div_ready;
    logic        roll_over;
    logic        clk_level;
    logic        running;
`ifdef CLOCK_SEQ_BURST_EN
    logic [7:0]  blen;
    logic        bstart;
    logic        bdone;
`endif

    always #5 clk = ~clk;

    clock_seq #(.W_DIV(16), .DEFAULT_DIV(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_run         (run),
        .i_div_valid   (div_valid),
        .i_div         (div),
        .o_div_ready   (div_ready),
        .o_roll_over   (roll_over),
        .o_clk_level   (clk_level),
        .o_running     (running)
`ifdef CLOCK_SEQ_BURST_EN
        ,
        .i_burst_len   (blen),
        .i_burst_start (bstart),
        .o_burst_done  (bdone)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: absolute edge number of the next rollover plus a few mode flags.
    int e_now    = 0;
    bit m_on     = 0;   // RUN or DRAIN
    bit m_drain  = 0;
    bit m_burst  = 0;
    bit m_level  = 1;
    int m_div    = 4;
    int m_end    = 0;
    int m_rem    = 0;
    int roll_cnt = 0;
    int done_cnt = 0;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: got %0b expected %0b", tag, e_now, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input int d, input bit bs, input int bl);
        bit was_idle;
        bit ready_exp;
        bit roll_exp;
        bit done_exp;
        run       = r;
        div_valid = v;
        div       = d[15:0];
`ifdef CLOCK_SEQ_BURST_EN
        bstart    = bs;
        blen      = bl[7:0];
`endif
        was_idle  = !m_on && !m_burst;
        ready_exp = was_idle || (m_on && !m_drain && (e_now + 1 == m_end));
        chk("div_ready", div_ready, ready_exp);
        @(posedge clk);
        e_now++;
        #1;
        roll_exp = (m_on || m_burst) && (e_now == m_end);
        done_exp = 1'b0;
        if (v && ready_exp) begin
            m_div = d & 16'hFFFF;
            $display("edge %0d: divisor %0d accepted", e_now, m_div);
        end
        if (roll_exp) begin
            m_level = !m_level;
            m_end   = e_now + eff(m_div);
        end
        if (was_idle) begin
`ifdef CLOCK_SEQ_BURST_EN
            if (bs && bl != 0) begin
                m_burst = 1;
                m_rem   = 2 * bl;
                m_end   = e_now + eff(m_div);
            end else
`endif
            if (r) begin
                m_on    = 1;
                m_drain = 0;
                m_end   = e_now + eff(m_div);
            end
        end else if (m_burst) begin
            if (roll_exp) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_burst  = 0;
                    done_exp = 1'b1;
                end
            end
        end else if (m_drain) begin
            if (roll_exp) begin
                m_on    = 0;
                m_drain = 0;
            end
        end else if (!r) begin
            if (m_level) m_on = 0;
            else         m_drain = 1;
        end
        if (roll_over) roll_cnt++;
        chk("roll_over", roll_over, roll_exp);
        chk("clk_level", clk_level, m_level);
        chk("running", running, m_on);
`ifdef CLOCK_SEQ_BURST_EN
        if (bdone) done_cnt++;
        chk("burst_done", bdone, done_exp);
`else
        if (done_exp) done_cnt++;
`endif
    endtask

    task automatic run_until_level(input bit lvl);
        for (int i = 0; i < 200; i++) begin
            if (m_level == lvl) break;
            step(1, 0, 0, 0, 0);
        end
        checks++;
        assert (m_level == lvl) else begin
            errors++;
            $error("FAIL level_wait: level never reached %0b", lvl);
        end
    endtask

    task automatic model_reset();
        m_on    = 0;
        m_drain = 0;
        m_burst = 0;
        m_level = 1;
        m_div   = 4;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_roll"}, roll_over, 1'b0);
        chk({tag, "_level"}, clk_level, 1'b1);
        chk({tag, "_running"}, running, 1'b0);
        chk({tag, "_ready"}, div_ready, 1'b1);
`ifdef CLOCK_SEQ_BURST_EN
        chk({tag, "_done"}, bdone, 1'b0);
`endif
    endtask

    initial begin
        rst_n     = 1'b1;
        run       = 1'b0;
        div_valid = 1'b0;
        div       = '0;
`ifdef CLOCK_SEQ_BURST_EN
        bstart    = 1'b0;
        blen      = '0;
`endif
        #1 rst_n = 1'b0;
        #1;
        chk_reset_values("rst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();

        $display("phase: idle then run with default divisor 4");
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        run_until_level(0);
        run_until_level(1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("phase: divisor 0 and 1");
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        run_until_level(1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        run_until_level(1);
        step(0, 0, 0, 0, 0);

        $display("phase: divisor 4 running, offer 7 mid-period");
        step(0, 1, 4, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 7, 0, 0);
        for (int i = 0; i < 24; i++) step(1, 0, 0, 0, 0);
        chk_int("div_after_offer", m_div, 7);

        $display("phase: stop with level low (drain) and level high");
        run_until_level(1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0);
        run_until_level(0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        run_until_level(0);
        run_until_level(1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("phase: asynchronous reset mid-period with level low");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        run_until_level(0);
        step(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(posedge clk);
        #1;
        chk_reset_values("midrst_hold");
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
        run_until_level(1);
        step(0, 0, 0, 0, 0);

`ifdef CLOCK_SEQ_BURST_EN
        $display("phase: burst len 3 with divisor 2");
        step(0, 1, 2, 0, 0);
        roll_cnt = 0;
        done_cnt = 0;
        step(0, 0, 0, 1, 3);
        for (int i = 0; i < 12; i++) step(1, 0, 0, (i == 3), 5);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk_int("burst_rolls", roll_cnt, 6);
        chk_int("burst_done_pulses", done_cnt, 1);
        chk("burst_end_level", clk_level, 1'b1);
        $display("phase: burst len 0 ignored");
        roll_cnt = 0;
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk_int("burst_len0_rolls", roll_cnt, 0);
`endif

        $display("phase: random stimulus");
        for (int i = 0; i < 1000; i++) begin
            bit r;
            bit v;
            bit bs;
            int d;
            int bl;
            r  = ($urandom_range(0, 7) != 0);
            v  = ($urandom_range(0, 3) == 0);
            d  = int'($urandom_range(0, 9));
`ifdef CLOCK_SEQ_BURST_EN
            bs = ($urandom_range(0, 15) == 0);
`else
            bs = 1'b0;
`endif
            bl = int'($urandom_range(0, 3));
            step(r, v, d, bs, bl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clock_seq.md
# clock_seq

Controller that sequences the toggle-clock generator: it produces the one-cycle rollover strobe that drives the downstream `clock` toggle stage, from a programmable divisor on the system clock. Handles start/stop with the generated clock always parked high, and accepts divisor updates only at period boundaries so the generated clock never emits a runt phase. Sits between the system clock domain and every `clock` instance's `i_roll_over` input.

## Interface
- `W_DIV`, 16, width of the divisor and period counter
- `DEFAULT_DIV`, 4, divisor value after reset

- `i_clk`  in  1  system clock, all state on posedge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_run`  in  1  level; 1 = generate rollovers, 0 = stop (parks clock high)
- `i_div_valid`  in  1  new divisor offered
- `i_div`  in  W_DIV  new divisor (system clocks per rollover)
- `o_div_ready`  out  1  divisor accepted when `i_div_valid && o_div_ready`
- `o_roll_over`  out  1  registered one-cycle strobe to the toggle stage
- `o_clk_level`  out  1  mirror of the toggle stage's output level
- `o_running`  out  1  1 in RUN or DRAIN
- `i_burst_len`  in  8  burst length in full output clock periods (macro only)
- `i_burst_start`  in  1  one-cycle burst request (macro only)
- `o_burst_done`  out  1  one-cycle pulse at burst end (macro only)

## Operation
- Reset values: state IDLE, counter 0, divisor `DEFAULT_DIV`, `o_roll_over` 0, `o_clk_level` 1, `o_running` 0, `o_burst_done` 0. Asserting reset mid-operation returns everything to these values immediately; no rollover is emitted.
- States: IDLE, RUN, DRAIN (BURST added with the macro).
- IDLE: counter held 0. `i_run`=1 -> RUN.
- RUN: counter counts 0..div-1 and wraps. At count div-1 the next edge sets `o_roll_over`=1 for one cycle and inverts `o_clk_level`.
  - `i_run`=0 with `o_clk_level`=1 -> IDLE next cycle, counter cleared.
  - `i_run`=0 with `o_clk_level`=0 -> DRAIN.
- DRAIN: keeps counting. The rollover that returns the level to 1 -> IDLE on the same edge. `i_run` is ignored in DRAIN.
- Divisor width rule: divisor 0 is treated as 1, giving a rollover every cycle. The counter is W_DIV bits; the maximum period is 2^W_DIV − 1.
- Divisor handshake:
  - `o_div_ready`=1 always in IDLE.
  - In RUN, `o_div_ready`=1 only in the cycle where count = div-1.
  - `o_div_ready`=0 in DRAIN and BURST.
  - An accepted divisor takes effect from the next period. The period in progress completes with the old value.
  - `o_div_ready` does not depend on `i_div_valid`.

## Timing
- If RUN is entered at edge T (count 0), the first `o_roll_over` is high in cycle T+div. After that, one strobe every div cycles.
- `o_clk_level` changes on the same edge that raises `o_roll_over`.
- `o_running` is registered with the state.
- Stop latency:
  - 1 cycle if the level is already high.
  - Otherwise, up to div cycles until the next rollover.
- Simultaneous events:
  - A rollover and `i_run` falling in the same cycle: the rollover completes first, and the updated level decides between IDLE and DRAIN.
  - A divisor accepted in the same cycle as a stop: the new divisor is retained for the next run.

## Configuration
- Macro: `CLOCK_SEQ_BURST_EN`.
- Defined: adds the burst ports and a BURST state.
  - Entry: in IDLE, `i_burst_start`=1 with `i_burst_len`≠0 -> BURST. This has priority over `i_run`.
  - `i_burst_len` is latched on entry. BURST emits exactly 2×len rollovers, then returns to IDLE with the level high and `o_burst_done`=1 for one cycle.
  - `i_run` and `i_burst_start` are ignored during BURST. `i_burst_len`=0 is ignored.
- Not defined: the burst ports and BURST state are absent. `o_burst_done` does not exist, and the behaviour is exactly as above.

## Test plan
- Reset, then `i_run`=1 with div=4: first strobe 4 cycles after RUN entry, then every 4 cycles. The level sequence is 1,0,1,0…
- div=0 and div=1: a strobe every cycle in RUN.
- div=4 running; offer `i_div`=7 mid-period: ready is asserted only at count 3. After acceptance, the next period is 7 cycles, and no short or long period appears.
- Drop `i_run` while the level is 0 with div=5: DRAIN, one more strobe, level 1, IDLE. Drop `i_run` while the level is 1: IDLE next cycle with no strobe.
- Assert `i_reset`=0 mid-period with the level at 0: the level goes to 1 and the strobe to 0 immediately. After release, stays in IDLE until `i_run`.
- With `CLOCK_SEQ_BURST_EN`, len=3, div=2: exactly 6 strobes, then `o_burst_done` for one pulse, IDLE, level 1. len=0 produces no activity.
